// File: rtl/game_pkg.sv
// Shared types and helpers for the match sequencer: state encoding, winner
// codes, score ceiling and the level-to-bullet-divider mapping.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int SCORE_MAX = 99;

  // L1..L4 -> 4..1 frame_ticks per bullet step
  function automatic logic [2:0] level_div(input logic [3:0] level_num);
    return 3'd5 - level_num[2:0];
  endfunction

endpackage

// File: rtl/step_divider.sv
// Frame-tick divider: emits a one-cycle step strobe every div enabled ticks.
// Holding en low freezes the count, so a paused game resumes mid-period.
module step_divider
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       tick,
  input  logic [2:0] div,
  output logic       step
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= 3'd0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (en && tick) begin
        if (cnt == div - 3'd1) begin
          cnt  <= 3'd0;
          step <= 1'b1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Match sequencer for the two-player shooter: owns game state, serve
// countdown, scoring with win detection, and the bullet step strobe.
//
// state   | meaning
// IDLE    | power-up, waiting for start
// SERVE   | countdown before play, start ignored
// PLAY    | movement/firing enabled, hits score
// PAUSED  | everything frozen until pause pressed again
// OVER    | winner held, start begins a new match
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE      = 20,
  parameter int SERVE_SECS     = 3,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_evt,
  input  logic       pause_evt,
  input  logic [1:0] level_sw,
  input  logic       hit1_wall,
  input  logic       hit1_player,
  input  logic       hit2_wall,
  input  logic       hit2_player,
  output logic [2:0] state,
  output logic       play_en,
  output logic       bullet_step,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [1:0] winner,
  output logic [3:0] level_num,
  output logic [3:0] countdown
);

  localparam int FW = $clog2(FRAMES_PER_SEC + 1);

  state_t        st;
  logic [FW-1:0] frame_cnt;
  logic [8:0]    sum1, sum2;
  logic [7:0]    nx1, nx2;
  logic          win1, win2, win_now, start_go;

  assign state = st;

  // wall hit is worth 2, player hit 1, so {wall, player} is the increment
  always_comb begin
    sum1    = {1'b0, score1} + 9'({hit1_wall, hit1_player});
    sum2    = {1'b0, score2} + 9'({hit2_wall, hit2_player});
    nx1     = (sum1 > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum1[7:0];
    nx2     = (sum2 > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : sum2[7:0];
    win1    = (nx1 >= 8'(WIN_SCORE));
    win2    = (nx2 >= 8'(WIN_SCORE));
    win_now = (st == ST_PLAY) && (win1 || win2);
    start_go = start_evt && ((st == ST_IDLE) || (st == ST_OVER));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      play_en   <= 1'b0;
      score1    <= 8'd0;
      score2    <= 8'd0;
      winner    <= WIN_NONE;
      level_num <= 4'd1;
      countdown <= 4'd0;
      frame_cnt <= '0;
    end else begin
      case (st)
        ST_IDLE, ST_OVER: begin
          if (start_evt) begin
            st        <= ST_SERVE;
            score1    <= 8'd0;
            score2    <= 8'd0;
            winner    <= WIN_NONE;
            level_num <= 4'(level_sw) + 4'd1;
            countdown <= 4'(SERVE_SECS);
            frame_cnt <= '0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
              frame_cnt <= '0;
              countdown <= countdown - 4'd1;
              if (countdown == 4'd1) begin
                st      <= ST_PLAY;
                play_en <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
        end
        ST_PLAY: begin
          score1 <= nx1;
          score2 <= nx2;
          if (win_now) begin
            st      <= ST_OVER;
            play_en <= 1'b0;
            winner  <= {win2, win1};
          end else if (pause_evt) begin
            st      <= ST_PAUSED;
            play_en <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause_evt) begin
            st      <= ST_PLAY;
            play_en <= 1'b1;
          end
        end
        default: begin
          st      <= ST_IDLE;
          play_en <= 1'b0;
        end
      endcase
    end
  end

  // the winning edge must not launch one more bullet step
  step_divider u_step (
    .clk  (clk),
    .rst  (rst),
    .en   ((st == ST_PLAY) && !win_now),
    .clr  (start_go),
    .tick (frame_tick),
    .div  (level_div(level_num)),
    .step (bullet_step)
  );

endmodule
